// File: rtl/mp3_trigger_sequencer.sv
// Queued trigger sequencer: requests enter a FIFO and are played one at a time
// as a single active-low pulse on trigger_out[n], followed by an all-high gap.
//
// Ports:
//   clock, reset    : rising-edge clock, synchronous active-high reset
//   play_req        : request strobe
//   Number_to_Play  : track number 1..NUM_TRIGGERS for the request
//   trigger_out     : registered active-low trigger lines [NUM_TRIGGERS:1]
//   busy            : FSM not idle or FIFO not empty
//   req_ack/req_err : one-cycle accept/reject pulse for the previous-edge request
//   queue_full      : FIFO holds QUEUE_DEPTH entries
module mp3_trigger_sequencer #(
  parameter int NUM_TRIGGERS = 18,
  parameter int SEL_WIDTH    = 6,
  parameter int PULSE_CYCLES = 1666,
  parameter int GAP_CYCLES   = 1666,
  parameter int QUEUE_DEPTH  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    play_req,
  input  logic [SEL_WIDTH-1:0]    Number_to_Play,
  output logic [NUM_TRIGGERS:1]   trigger_out,
  output logic                    busy,
  output logic                    req_ack,
  output logic                    req_err,
  output logic                    queue_full
);

  localparam int PW  = $clog2(QUEUE_DEPTH);
  localparam int CW  = PW + 1;
  localparam int PCW = $clog2(PULSE_CYCLES + 1);
  localparam int GCW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_GAP
  } state_t;

  state_t               r_state;
  logic [SEL_WIDTH-1:0] r_mem [QUEUE_DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic [PCW-1:0]       r_pulse_cnt;
  logic [GCW-1:0]       r_gap_cnt;

  logic                  w_valid;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic [SEL_WIDTH-1:0]  w_head;
  logic [NUM_TRIGGERS:1] w_low_mask;

  assign w_empty    = (r_count == '0);
  assign queue_full = (r_count == CW'(QUEUE_DEPTH));
  assign w_valid    = play_req
                    && (Number_to_Play != '0)
                    && (Number_to_Play <= SEL_WIDTH'(NUM_TRIGGERS));
  // Full is judged on pre-edge occupancy, so a pop on the same edge
  // does not make room for a push.
  assign w_push     = w_valid && !queue_full;
  assign w_pop      = (r_state == S_IDLE) && !w_empty;
  assign w_head     = r_mem[r_rd_ptr];
  assign busy       = (r_state != S_IDLE) || !w_empty;

  always_comb begin
    w_low_mask = '0;
    for (int i = 1; i <= NUM_TRIGGERS; i++) begin
      if (w_head == SEL_WIDTH'(i)) w_low_mask[i] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= Number_to_Play;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      req_ack  <= 1'b0;
      req_err  <= 1'b0;
    end else begin
      req_ack <= w_push;
      req_err <= play_req && !w_push;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      trigger_out <= '1;
      r_pulse_cnt <= '0;
      r_gap_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state     <= S_PULSE;
            r_pulse_cnt <= PCW'(PULSE_CYCLES);
            trigger_out <= ~w_low_mask;
          end
        end
        S_PULSE: begin
          if (r_pulse_cnt == PCW'(1)) begin
            r_state     <= S_GAP;
            r_gap_cnt   <= GCW'(GAP_CYCLES);
            trigger_out <= '1;
          end else begin
            r_pulse_cnt <= r_pulse_cnt - PCW'(1);
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GCW'(1)) r_state <= S_IDLE;
          else r_gap_cnt <= r_gap_cnt - GCW'(1);
        end
        default: begin
          r_state     <= S_IDLE;
          trigger_out <= '1;
        end
      endcase
    end
  end

endmodule

// File: doc/mp3_trigger_sequencer.md
MP3_TRIGGER_SEQUENCER -- requirements
Module: mp3_trigger_sequencer

Interface
REQ-001 Parameter NUM_TRIGGERS, default 18: number of active-low trigger outputs, numbered 1..NUM_TRIGGERS.
REQ-002 Parameter SEL_WIDTH, default 6: width of the track-select input; SHALL satisfy 2^SEL_WIDTH > NUM_TRIGGERS.
REQ-003 Parameter PULSE_CYCLES, default 1666: clock cycles a trigger is held low; minimum 1.
REQ-004 Parameter GAP_CYCLES, default 1666: clock cycles all triggers are held high after each pulse; minimum 1.
REQ-005 Parameter QUEUE_DEPTH, default 4: request FIFO entries; power of two, minimum 2.
REQ-006 clock  input  1  single system clock; all state SHALL update on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 play_req  input  1  request strobe, sampled on each rising edge.
REQ-009 Number_to_Play  input  SEL_WIDTH  track number for the request, valid when play_req=1.
REQ-010 trigger_out  output  NUM_TRIGGERS, indexed [NUM_TRIGGERS:1]  registered, active-low trigger lines.
REQ-011 busy  output  1  high while state is not IDLE or the FIFO is non-empty.
REQ-012 req_ack  output  1  one-cycle pulse: the previous-edge request was queued.
REQ-013 req_err  output  1  one-cycle pulse: the previous-edge request was rejected (invalid number or FIFO full).
REQ-014 queue_full  output  1  high when the FIFO holds QUEUE_DEPTH entries.

Function
REQ-015 Valid request: play_req=1 and 1 <= Number_to_Play <= NUM_TRIGGERS; 0 and values above NUM_TRIGGERS SHALL be invalid.
REQ-016 A valid request sampled while queue_full=0 SHALL be written to the FIFO on that edge, and req_ack SHALL be 1 in the following cycle.
REQ-017 An invalid request, or a valid request sampled while queue_full=1, SHALL be dropped without altering the FIFO, and req_err SHALL be 1 in the following cycle.
REQ-018 Full status SHALL use pre-edge occupancy: a push and a pop on the same edge while full SHALL reject the push.
REQ-019 A push and a pop on the same edge while not full SHALL leave occupancy unchanged; the FIFO SHALL preserve FIFO order.
REQ-020 There SHALL be no bypass: an empty FIFO SHALL NOT issue a pulse in the same cycle as a push.
REQ-021 The FSM SHALL have states IDLE, PULSE and GAP.
REQ-022 IDLE with the FIFO non-empty SHALL pop the head, load the pulse counter, and enter PULSE on that edge.
REQ-023 In PULSE, exactly bit trigger_out[n] SHALL be 0 for exactly PULSE_CYCLES cycles, where n is the popped number.
REQ-024 PULSE SHALL then enter GAP; in GAP, all trigger_out bits SHALL be 1 for exactly GAP_CYCLES cycles.
REQ-025 GAP SHALL return to IDLE; back-to-back queued requests SHALL therefore be separated by exactly GAP_CYCLES+1 high cycles.
REQ-026 Latency SHALL be fixed: a request sampled at edge k into an empty, idle block drives its trigger low in the cycle after edge k+1.
REQ-027 Outside PULSE, trigger_out SHALL be all ones; at most one bit SHALL be 0 in any cycle.
REQ-028 Counters SHALL be sized by $clog2 of the respective parameter+1, SHALL count down to 1, and SHALL never wrap.
REQ-029 The FIFO read and write pointers SHALL wrap modulo QUEUE_DEPTH; occupancy SHALL be held in a separate counter of width $clog2(QUEUE_DEPTH)+1.

Reset
REQ-030 reset=1 on an edge SHALL force: state IDLE, FIFO empty, trigger_out all ones, busy=0, req_ack=0, req_err=0, queue_full=0.
REQ-031 Reset SHALL override any simultaneous play_req, including one arriving mid-PULSE, and SHALL abort the pulse with no residual low cycle.
REQ-032 Reset SHALL take priority over all other inputs; the first request SHALL be accepted on the first edge after reset deasserts.

Verification (PULSE_CYCLES=4, GAP_CYCLES=3, QUEUE_DEPTH=4, NUM_TRIGGERS=18)
REQ-033 Single play of 5 at edge k -> req_ack=1 in cycle k+1; trigger_out[5]=0 for cycles k+2..k+5; all high for k+6..k+8; busy=0 from k+9.
REQ-034 Numbers 0, 19 and 63 -> req_err pulse for each; FIFO empty; trigger_out stays all ones; busy stays 0.
REQ-035 Six consecutive valid requests (1..6) on consecutive edges while the first is pulsing -> four are acked, the remainder get req_err, queue_full asserts, and pulses appear in order with 4 low / 4 high spacing.
REQ-036 Push while full, coincident with a pop -> push rejected (req_err=1); occupancy goes from 4 to 3.
REQ-037 reset during the 2nd low cycle of trigger 18 with 2 requests queued -> next cycle all ones, busy=0; no further pulses.
REQ-038 Request for 18 on the first edge after reset -> accepted; trigger_out[18] low with the REQ-026 latency.
